title_menu_ctrl: RTL and testbench

//  Sequences title selection for the VGA text display: conditions the raw up/down buttons
//  (synchronise, debounce, edge-detect) and steps a wrapping title index.

---
 rtl/title_menu_pkg.sv | 9 +
 rtl/title_menu_ctrl_btn_debounce.sv | 41 ++++
 rtl/title_menu_ctrl.sv | 163 ++++++++++++++++
 tb/tb_title_menu_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/title_menu_pkg.sv
// Shared types and defaults for the title-menu controller.
package title_menu_pkg;

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} menu_state_t;
    typedef enum logic {DIR_DN, DIR_UP} menu_dir_t;

    localparam int DB_CYC_DEF = 750000;

endpackage

// File: rtl/title_menu_ctrl_btn_debounce.sv
// Button conditioner: 2-flop synchroniser followed by a stable-level counter.
module btn_debounce
    import title_menu_pkg::*;
#(
    parameter int DB_CYC = DB_CYC_DEF
) (
    input  logic clk_pix,
    input  logic rst_n,
    input  logic btn,
    output logic lvl
);

    localparam int CW = $clog2(DB_CYC + 1);

    logic          sync_p0;
    logic          sync_p1;
    logic [CW-1:0] cnt;

    // Counter only runs while the synchronised level disagrees with the accepted one,
    // so any bounce back to the old level restarts the count.
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            lvl     <= 1'b0;
            cnt     <= '0;
        end else begin
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
            if (sync_p1 == lvl) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CYC - 1)) begin
                lvl <= sync_p1;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/title_menu_ctrl.sv
// Title selection controller: debounced up/down buttons step a wrapping index at frame start.
// Optional auto-repeat while a button is held is enabled by defining AUTO_REPEAT_EN.
module title_menu_ctrl
    import title_menu_pkg::*;
#(
    parameter int N_TITLES = 3,
    parameter int DB_CYC   = DB_CYC_DEF,
`ifdef AUTO_REPEAT_EN
    parameter int RPT_DELAY = 30,
    parameter int RPT_RATE  = 8,
`endif
    localparam int IDXW = $clog2(N_TITLES)
) (
    input  logic            clk_pix,
    input  logic            rst_pix_n,
    input  logic            btnu,
    input  logic            btnd,
    input  logic            frame,
    output logic [IDXW-1:0] idx,
    output logic            sel_stb,
    output logic            pend
);

    function automatic logic [IDXW-1:0] step_idx(input logic [IDXW-1:0] cur, input menu_dir_t d);
        if (d == DIR_UP) return (cur == IDXW'(N_TITLES - 1)) ? '0 : cur + 1'b1;
        else             return (cur == '0) ? IDXW'(N_TITLES - 1) : cur - 1'b1;
    endfunction

    logic [1:0]  rst_sync;
    logic        rst_n;
    logic        dbu, dbd;
    logic        dbu_q, dbd_q;
    logic        rise_u, rise_d;
    logic        ev;
    menu_dir_t   ev_dir;
    menu_state_t state, state_nxt;
    menu_dir_t   hold_dir, hold_dir_nxt;
    menu_dir_t   q_dir, pend_dir;
    logic        q_set;
    logic        held_lvl;

    // Reset asserts immediately but releases on a clock edge.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) rst_sync <= 2'b00;
        else            rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    btn_debounce #(.DB_CYC(DB_CYC)) u_db_up (.clk_pix(clk_pix), .rst_n(rst_n), .btn(btnu), .lvl(dbu));
    btn_debounce #(.DB_CYC(DB_CYC)) u_db_dn (.clk_pix(clk_pix), .rst_n(rst_n), .btn(btnd), .lvl(dbd));

    assign rise_u   = dbu & ~dbu_q;
    assign rise_d   = dbd & ~dbd_q;
    assign ev       = (rise_u & ~dbd) | (rise_d & ~dbu);
    assign ev_dir   = (rise_u & ~dbd) ? DIR_UP : DIR_DN;
    assign held_lvl = (hold_dir == DIR_UP) ? dbu : dbd;

`ifdef AUTO_REPEAT_EN
    localparam int RPT_MAX = (RPT_DELAY > RPT_RATE) ? RPT_DELAY : RPT_RATE;
    localparam int FCW     = $clog2(RPT_MAX + 1);
    logic [FCW-1:0] fcnt, fcnt_nxt;
`endif

    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hold_dir <= DIR_DN;
            dbu_q    <= 1'b0;
            dbd_q    <= 1'b0;
`ifdef AUTO_REPEAT_EN
            fcnt     <= '0;
`endif
        end else begin
            state    <= state_nxt;
            hold_dir <= hold_dir_nxt;
            dbu_q    <= dbu;
            dbd_q    <= dbd;
`ifdef AUTO_REPEAT_EN
            fcnt     <= fcnt_nxt;
`endif
        end
    end

    // Both buttons down overrides everything; a fresh press always (re)enters HOLD.
    always_comb begin
        state_nxt    = state;
        hold_dir_nxt = hold_dir;
        q_set        = 1'b0;
        q_dir        = hold_dir;
`ifdef AUTO_REPEAT_EN
        fcnt_nxt     = fcnt;
`endif
        if (dbu && dbd) begin
            state_nxt = IDLE;
`ifdef AUTO_REPEAT_EN
            fcnt_nxt  = '0;
`endif
        end else if (ev) begin
            state_nxt    = HOLD;
            hold_dir_nxt = ev_dir;
            q_set        = 1'b1;
            q_dir        = ev_dir;
`ifdef AUTO_REPEAT_EN
            fcnt_nxt     = '0;
`endif
        end else begin
            case (state)
                HOLD: begin
                    if (!held_lvl) begin
                        state_nxt = IDLE;
`ifdef AUTO_REPEAT_EN
                        fcnt_nxt  = '0;
                    end else if (frame) begin
                        if (fcnt == FCW'(RPT_DELAY - 1)) begin
                            state_nxt = REPEAT;
                            q_set     = 1'b1;
                            fcnt_nxt  = '0;
                        end else begin
                            fcnt_nxt = fcnt + 1'b1;
                        end
`endif
                    end
                end
`ifdef AUTO_REPEAT_EN
                REPEAT: begin
                    if (!held_lvl) begin
                        state_nxt = IDLE;
                        fcnt_nxt  = '0;
                    end else if (frame) begin
                        if (fcnt == FCW'(RPT_RATE - 1)) begin
                            q_set    = 1'b1;
                            fcnt_nxt = '0;
                        end else begin
                            fcnt_nxt = fcnt + 1'b1;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // One-entry step queue; a step queued on a frame cycle waits for the following frame.
    always_ff @(posedge clk_pix or negedge rst_n) begin
        if (!rst_n) begin
            idx      <= '0;
            sel_stb  <= 1'b0;
            pend     <= 1'b0;
            pend_dir <= DIR_DN;
        end else begin
            sel_stb <= frame & pend;
            if (frame && pend) idx <= step_idx(idx, pend_dir);
            if (q_set) begin
                pend     <= 1'b1;
                pend_dir <= q_dir;
            end else if (frame) begin
                pend <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_title_menu_ctrl.sv
// Directed bench for title_menu_ctrl (DB_CYC=4, N_TITLES=3, RPT_DELAY=2, RPT_RATE=1).
module tb_title_menu_ctrl;

    logic       clk_pix = 1'b0;
    logic       rst_pix_n = 1'b0;
    logic       btnu = 1'b0;
    logic       btnd = 1'b0;
    logic       frame = 1'b0;
    logic [1:0] idx;
    logic       sel_stb;
    logic       pend;

    int n_tests = 0;
    int n_fail  = 0;

    title_menu_ctrl #(
        .N_TITLES(3),
`ifdef AUTO_REPEAT_EN
        .RPT_DELAY(2),
        .RPT_RATE(1),
`endif
        .DB_CYC(4)
    ) dut (
        .clk_pix(clk_pix), .rst_pix_n(rst_pix_n), .btnu(btnu), .btnd(btnd),
        .frame(frame), .idx(idx), .sel_stb(sel_stb), .pend(pend)
    );

    always #5 clk_pix = ~clk_pix;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_pix);
            #1;
        end
    endtask

    task automatic do_reset();
        rst_pix_n = 1'b0; btnu = 1'b0; btnd = 1'b0; frame = 1'b0;
        tick(2);
        rst_pix_n = 1'b1;
        tick(3);
    endtask

    task automatic pulse_frame();
        frame = 1'b1;
        tick(1);
        frame = 1'b0;
    endtask

    // Press, release, let the release debounce, then apply at a frame (19 cycles).
    task automatic do_press(input logic u, input logic d);
        btnu = u; btnd = d;
        tick(10);
        btnu = 1'b0; btnd = 1'b0;
        tick(8);
        pulse_frame();
    endtask

    task automatic test_reset();
        rst_pix_n = 1'b0;
        tick(3);
        n_tests++; if (idx !== 2'd0)   begin n_fail++; $display("FAIL rst_idx: got %0d expected 0", idx); end
        n_tests++; if (sel_stb !== 1'b0) begin n_fail++; $display("FAIL rst_sel: got %0d expected 0", sel_stb); end
        n_tests++; if (pend !== 1'b0)  begin n_fail++; $display("FAIL rst_pend: got %0d expected 0", pend); end
        rst_pix_n = 1'b1;
        tick(4);
        n_tests++; if (idx !== 2'd0)   begin n_fail++; $display("FAIL rel_idx: got %0d expected 0", idx); end
        n_tests++; if (pend !== 1'b0)  begin n_fail++; $display("FAIL rel_pend: got %0d expected 0", pend); end
    endtask

    task automatic test_basic();
        btnu = 1'b1;
        tick(10);
        n_tests++; if (pend !== 1'b1)  begin n_fail++; $display("FAIL basic_pend_set: got %0d expected 1", pend); end
        btnu = 1'b0;
        tick(8);
        n_tests++; if (idx !== 2'd0)   begin n_fail++; $display("FAIL basic_idx_wait: got %0d expected 0", idx); end
        n_tests++; if (sel_stb !== 1'b0) begin n_fail++; $display("FAIL basic_sel_early: got %0d expected 0", sel_stb); end
        pulse_frame();
        n_tests++; if (idx !== 2'd1)   begin n_fail++; $display("FAIL basic_idx: got %0d expected 1", idx); end
        n_tests++; if (sel_stb !== 1'b1) begin n_fail++; $display("FAIL basic_sel: got %0d expected 1", sel_stb); end
        n_tests++; if (pend !== 1'b0)  begin n_fail++; $display("FAIL basic_pend_clr: got %0d expected 0", pend); end
        tick(1);
        n_tests++; if (sel_stb !== 1'b0) begin n_fail++; $display("FAIL basic_sel_1cyc: got %0d expected 0", sel_stb); end
        n_tests++; if (idx !== 2'd1)   begin n_fail++; $display("FAIL basic_idx_hold: got %0d expected 1", idx); end
    endtask

    task automatic test_wrap();
        logic [1:0] exp_up [3];
        exp_up = '{2'd1, 2'd2, 2'd0};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            do_press(1'b1, 1'b0);
            n_tests++; if (idx !== exp_up[i]) begin n_fail++; $display("FAIL wrap_up%0d: got %0d expected %0d", i, idx, exp_up[i]); end
            n_tests++; if (sel_stb !== 1'b1)  begin n_fail++; $display("FAIL wrap_up_sel%0d: got %0d expected 1", i, sel_stb); end
            tick(1);
        end
        do_press(1'b0, 1'b1);
        n_tests++; if (idx !== 2'd2) begin n_fail++; $display("FAIL wrap_dn: got %0d expected 2", idx); end
        tick(1);
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 5; i++) begin
            btnu = 1'b1; tick(2);
            btnu = 1'b0; tick(2);
        end
        tick(8);
        n_tests++; if (pend !== 1'b0) begin n_fail++; $display("FAIL bounce_pend: got %0d expected 0", pend); end
        pulse_frame();
        n_tests++; if (idx !== 2'd2)    begin n_fail++; $display("FAIL bounce_idx: got %0d expected 2", idx); end
        n_tests++; if (sel_stb !== 1'b0) begin n_fail++; $display("FAIL bounce_sel: got %0d expected 0", sel_stb); end
        tick(1);
    endtask

    task automatic test_both_and_last_wins();
        btnu = 1'b1; btnd = 1'b1;
        tick(40);
        btnu = 1'b0; btnd = 1'b0;
        tick(8);
        n_tests++; if (pend !== 1'b0) begin n_fail++; $display("FAIL both_pend: got %0d expected 0", pend); end
        pulse_frame();
        n_tests++; if (idx !== 2'd2)    begin n_fail++; $display("FAIL both_idx: got %0d expected 2", idx); end
        n_tests++; if (sel_stb !== 1'b0) begin n_fail++; $display("FAIL both_sel: got %0d expected 0", sel_stb); end
        tick(1);
        btnu = 1'b1; tick(8);
        btnu = 1'b0; tick(8);
        btnd = 1'b1; tick(8);
        btnd = 1'b0; tick(8);
        n_tests++; if (pend !== 1'b1) begin n_fail++; $display("FAIL lastwin_pend: got %0d expected 1", pend); end
        pulse_frame();
        n_tests++; if (idx !== 2'd1)    begin n_fail++; $display("FAIL lastwin_idx: got %0d expected 1", idx); end
        n_tests++; if (sel_stb !== 1'b1) begin n_fail++; $display("FAIL lastwin_sel: got %0d expected 1", sel_stb); end
        tick(1);
    endtask

    task automatic test_auto_repeat();
        logic [1:0] exp_f [5];
        logic [1:0] exp_end;
`ifdef AUTO_REPEAT_EN
        exp_f   = '{2'd1, 2'd1, 2'd2, 2'd0, 2'd1};
        exp_end = 2'd2;
`else
        exp_f   = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd1};
        exp_end = 2'd1;
`endif
        do_reset();
        btnu = 1'b1;
        tick(10);
        for (int f = 0; f < 5; f++) begin
            pulse_frame();
            n_tests++; if (idx !== exp_f[f]) begin n_fail++; $display("FAIL hold_frame%0d: got %0d expected %0d", f, idx, exp_f[f]); end
            tick(19);
        end
        btnu = 1'b0;
        tick(8);
        pulse_frame();
        n_tests++; if (idx !== exp_end) begin n_fail++; $display("FAIL hold_release: got %0d expected %0d", idx, exp_end); end
        n_tests++; if (pend !== 1'b0)   begin n_fail++; $display("FAIL hold_pend: got %0d expected 0", pend); end
        tick(19);
        pulse_frame();
        n_tests++; if (idx !== exp_end) begin n_fail++; $display("FAIL hold_settled: got %0d expected %0d", idx, exp_end); end
        tick(1);
    endtask

    task automatic test_reset_midop();
        do_reset();
        do_press(1'b1, 1'b0);
        tick(1);
        btnu = 1'b1; tick(10);
        btnu = 1'b0; tick(3);
        n_tests++; if (pend !== 1'b1) begin n_fail++; $display("FAIL midrst_pre_pend: got %0d expected 1", pend); end
        n_tests++; if (idx !== 2'd1)  begin n_fail++; $display("FAIL midrst_pre_idx: got %0d expected 1", idx); end
        #2;
        rst_pix_n = 1'b0;
        #1;
        n_tests++; if (idx !== 2'd0)  begin n_fail++; $display("FAIL midrst_idx: got %0d expected 0", idx); end
        n_tests++; if (pend !== 1'b0) begin n_fail++; $display("FAIL midrst_pend: got %0d expected 0", pend); end
        tick(2);
        rst_pix_n = 1'b1;
        tick(8);
        pulse_frame();
        n_tests++; if (sel_stb !== 1'b0) begin n_fail++; $display("FAIL midrst_sel: got %0d expected 0", sel_stb); end
        n_tests++; if (idx !== 2'd0)     begin n_fail++; $display("FAIL midrst_idx_after: got %0d expected 0", idx); end
        tick(1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_bounce();
        test_both_and_last_wins();
        test_auto_repeat();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
